channel_llr_store: RTL

Frame store directly downstream of the serial-to-parallel channel buffer. It captures each 128-LLR parallel block (P×Q bits) when the buffer signals ready, and assembles N/P blocks into one frame of channel LLRs. It then serves that frame by block address to the SCAN decoder core. Optional ping-pong banking lets the next frame load while the current one is being decoded.

---
 rtl/channel_llr_store.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/channel_llr_store.sv
// Channel LLR frame store: captures P*Q-bit blocks on buffer_ready rising edges and serves
// complete frames by block address. Define CH_STORE_PINGPONG_EN for two-bank ping-pong operation.
module channel_llr_store #(
    parameter int Q = 6,
    parameter int P = 128,
    parameter int N = 1024,
    localparam int AW = $clog2(N / P)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P*Q-1:0]   channel_set_LLR,
    input  logic             buffer_ready,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             frame_release,
    output logic [P*Q-1:0]   rd_data,
    output logic             rd_valid,
    output logic             frame_ready,
    output logic [AW-1:0]    wr_blk,
    output logic             overflow
);

    localparam int DEPTH = N / P;

`ifdef CH_STORE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int MW = $clog2(NB * DEPTH);

    logic [P*Q-1:0] mem [NB*DEPTH];

    logic           ready_q_reg;
    logic [AW-1:0]  wr_blk_reg, wr_blk_next;
    logic           overflow_reg;
    logic           rd_valid_reg;
    logic [P*Q-1:0] rd_data_reg;

    logic           capture, w_full, r_full;
    logic           wr_fire, wr_last, rel_fire, rd_fire;
    logic [MW-1:0]  wr_addr, rd_mem_addr;

    // All events are judged against pre-edge state.
    assign capture  = buffer_ready & ~ready_q_reg;
    assign wr_fire  = capture & ~w_full;
    assign wr_last  = wr_fire & (wr_blk_reg == AW'(DEPTH - 1));
    assign rel_fire = frame_release & r_full;
    assign rd_fire  = rd_en & r_full;

`ifdef CH_STORE_PINGPONG_EN
    logic       wbank_reg, wbank_next;
    logic       rbank_reg, rbank_next;
    logic [1:0] full_reg, full_next;

    assign w_full      = full_reg[wbank_reg];
    assign r_full      = full_reg[rbank_reg];
    assign wr_addr     = {wbank_reg, wr_blk_reg};
    assign rd_mem_addr = {rbank_reg, rd_addr};

    // A write can only complete into a non-full bank and a release only frees a full one,
    // so the two never target the same bank in one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        always_comb begin
            full_next[gi] = full_reg[gi];
            if (rel_fire && (rbank_reg == 1'(gi)))
                full_next[gi] = 1'b0;
            else if (wr_last && (wbank_reg == 1'(gi)))
                full_next[gi] = 1'b1;
        end
    end

    always_comb begin
        wbank_next = wbank_reg ^ wr_last;
        rbank_next = rbank_reg ^ rel_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbank_reg <= 1'b0;
            rbank_reg <= 1'b0;
            full_reg  <= 2'b00;
        end else begin
            wbank_reg <= wbank_next;
            rbank_reg <= rbank_next;
            full_reg  <= full_next;
        end
    end
`else
    logic full_reg, full_next;

    assign w_full      = full_reg;
    assign r_full      = full_reg;
    assign wr_addr     = wr_blk_reg;
    assign rd_mem_addr = rd_addr;

    always_comb begin
        full_next = full_reg;
        if (rel_fire)
            full_next = 1'b0;
        else if (wr_last)
            full_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            full_reg <= 1'b0;
        else
            full_reg <= full_next;
    end
`endif

    always_comb begin
        wr_blk_next = wr_blk_reg;
        if (wr_fire)
            wr_blk_next = wr_blk_reg + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q_reg  <= 1'b0;
            wr_blk_reg   <= '0;
            overflow_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            ready_q_reg  <= buffer_ready;
            wr_blk_reg   <= wr_blk_next;
            overflow_reg <= capture & w_full;
            rd_valid_reg <= rd_fire;
        end
    end

    // Frame memory is deliberately unreset; reads are gated by the bank-full flag.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_addr] <= channel_set_LLR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_data_reg <= '0;
        else if (rd_fire)
            rd_data_reg <= mem[rd_mem_addr];
    end

    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign frame_ready = r_full;
    assign wr_blk      = wr_blk_reg;
    assign overflow    = overflow_reg;

endmodule
